// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI frame sequencer.
// Contents:
//   - opcode constants (OP_WR_A .. OP_RD_STATUS)
//   - frame state enum seq_state_e
//   - default byte-address width and status byte bit positions
//   - status_byte() helper that packs the status byte
package spi_seq_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 6;

    localparam logic [7:0] OP_WR_A      = 8'h01;
    localparam logic [7:0] OP_WR_B      = 8'h02;
    localparam logic [7:0] OP_START     = 8'h03;
    localparam logic [7:0] OP_RD_RES    = 8'h04;
    localparam logic [7:0] OP_RD_STATUS = 8'h05;

    localparam int unsigned STAT_BUSY_BIT = 7;
    localparam int unsigned STAT_ERR_BIT  = 6;

    typedef enum logic [2:0] {
        CMD,
        ADDR,
        WDATA,
        RDATA,
        STATUS,
        IGNORE
    } seq_state_e;

    function automatic logic [7:0] status_byte(input logic busy, input logic err);
        logic [7:0] b;
        b                = 8'h00;
        b[STAT_BUSY_BIT] = busy;
        b[STAT_ERR_BIT]  = err;
        return b;
    endfunction

endpackage

// File: rtl/spi_frame_sequencer_if.sv
// Buffer-side bus of the SPI frame sequencer.
// Signals:
//   buf_wr_en/sel/addr/data - one-cycle byte write into operand buffer A (sel=0) or B (sel=1)
//   res_rd_addr             - result byte address; byte 4k is the MSB of word k
//   res_rd_data             - combinational read data for res_rd_addr
// Modports: master = sequencer, slave = buffer side.
interface spi_frame_sequencer_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              buf_wr_en;
    logic              buf_wr_sel;
    logic [ADDR_W-1:0] buf_wr_addr;
    logic [7:0]        buf_wr_data;
    logic [ADDR_W-1:0] res_rd_addr;
    logic [7:0]        res_rd_data;

    modport master (
        output buf_wr_en,
        output buf_wr_sel,
        output buf_wr_addr,
        output buf_wr_data,
        output res_rd_addr,
        input  res_rd_data
    );

    modport slave (
        input  buf_wr_en,
        input  buf_wr_sel,
        input  buf_wr_addr,
        input  buf_wr_data,
        input  res_rd_addr,
        output res_rd_data
    );
endinterface

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte shifter: receive on posedge sclk, transmit on negedge sclk, MSB first.
// Ports:
//   sclk, rst_n    - SPI clock, asynchronous active-low reset
//   cs_n           - chip select; high asynchronously clears bit count, load flag and miso
//   mosi           - serial in
//   tx_en_i        - transmit enabled in the current frame state (miso forced 0 otherwise)
//   tx_byte_i      - byte loaded on the negedge following each completed byte
//   byte_done_o    - high during the cycle whose posedge completes a byte
//   rx_byte_o      - completed byte, valid with byte_done_o
//   miso_o         - serial out (registered)
module spi_byte_shifter (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       mosi,
    input  logic       tx_en_i,
    input  logic [7:0] tx_byte_i,
    output logic       byte_done_o,
    output logic [7:0] rx_byte_o,
    output logic       miso_o
);

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic       load_q, load_d;
    logic [6:0] tx_shift_q, tx_shift_d;
    logic       miso_q, miso_d;

    assign byte_done_o = (bit_cnt_q == 3'd7);
    assign rx_byte_o   = {rx_shift_q, mosi};
    assign miso_o      = miso_q;

    always_comb begin
        bit_cnt_d  = bit_cnt_q + 3'd1;  // wraps 7 -> 0 on byte completion
        rx_shift_d = {rx_shift_q[5:0], mosi};
        load_d     = byte_done_o;       // tells the next negedge to load a fresh tx byte
    end

    always_ff @(posedge sclk or negedge rst_n or posedge cs_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 7'd0;
            load_q     <= 1'b0;
        end else if (cs_n) begin
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 7'd0;
            load_q     <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            load_q     <= load_d;
        end
    end

    // Bit 7 goes straight to miso on load, so only the lower seven bits are kept.
    always_comb begin
        tx_shift_d = {tx_shift_q[5:0], 1'b0};
        miso_d     = tx_shift_q[6];
        if (!tx_en_i) begin
            tx_shift_d = 7'd0;
            miso_d     = 1'b0;
        end else if (load_q) begin
            tx_shift_d = tx_byte_i[6:0];
            miso_d     = tx_byte_i[7];
        end
    end

    always_ff @(negedge sclk or negedge rst_n or posedge cs_n) begin
        if (!rst_n) begin
            tx_shift_q <= 7'd0;
            miso_q     <= 1'b0;
        end else if (cs_n) begin
            tx_shift_q <= 7'd0;
            miso_q     <= 1'b0;
        end else begin
            tx_shift_q <= tx_shift_d;
            miso_q     <= miso_d;
        end
    end

endmodule

// File: rtl/spi_frame_sequencer.sv
// SCLK-domain command sequencer between the SPI pins and the accelerator byte buffers.
// Decodes opcode frames, auto-increments byte addresses, drives buffer write/read ports,
// flips a CDC-safe start toggle and returns status/result bytes on MISO.
// Ports:
//   sclk, rst_n   - SPI clock (only clock), asynchronous active-low reset
//   cs_n          - chip select; high asynchronously aborts the frame
//   mosi, miso    - SPI mode-0 data, MSB first
//   buf_if        - buffer bus (write strobe/sel/addr/data, result read addr/data)
//   start_toggle  - flips once per accepted START
//   busy_async    - accelerator busy from the sys_clk domain
// Build option: define SPI_ECHO_EN to loop the previously received byte back on miso
// during the ADDR and WDATA states.
module spi_frame_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         sclk,
    input  logic                         rst_n,
    input  logic                         cs_n,
    input  logic                         mosi,
    output logic                         miso,
    spi_frame_sequencer_if.master        buf_if,
    output logic                         start_toggle,
    input  logic                         busy_async
);

    seq_state_e        state_q, state_d;
    logic              armed_q;
    logic              buf_wr_en_q, buf_wr_en_d;
    logic              buf_wr_sel_q, buf_wr_sel_d;
    logic [ADDR_W-1:0] buf_wr_addr_q, buf_wr_addr_d;
    logic [7:0]        buf_wr_data_q, buf_wr_data_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] res_rd_addr_q, res_rd_addr_d;
    logic              is_rd_q, is_rd_d;
    logic              start_toggle_q, start_toggle_d;
    logic              err_flag_q, err_flag_d;
    logic [SYNC_STAGES-1:0] busy_sync_q, busy_sync_d;
    logic              busy_s;

    logic              byte_done;
    logic              byte_ok;
    logic [7:0]        rx_byte;
    logic              tx_en;
    logic [7:0]        tx_byte;

`ifdef SPI_ECHO_EN
    logic [7:0]        echo_q, echo_d;
`endif

    spi_byte_shifter u_shifter (
        .sclk        (sclk),
        .rst_n       (rst_n),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .tx_en_i     (tx_en),
        .tx_byte_i   (tx_byte),
        .byte_done_o (byte_done),
        .rx_byte_o   (rx_byte),
        .miso_o      (miso)
    );

    // After a reset taken mid-frame the bit phase is unknown, so bytes are ignored until
    // cs_n has been seen high.
    assign byte_ok = byte_done && armed_q;
    assign busy_s  = busy_sync_q[SYNC_STAGES-1];

    assign buf_if.buf_wr_en   = buf_wr_en_q;
    assign buf_if.buf_wr_sel  = buf_wr_sel_q;
    assign buf_if.buf_wr_addr = buf_wr_addr_q;
    assign buf_if.buf_wr_data = buf_wr_data_q;
    assign buf_if.res_rd_addr = res_rd_addr_q;
    assign start_toggle       = start_toggle_q;

    always_comb begin
        busy_sync_d[0] = busy_async;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            busy_sync_d[i] = busy_sync_q[i-1];
        end
    end

    // Frame decode and next-state logic
    always_comb begin
        state_d        = state_q;
        buf_wr_en_d    = 1'b0;
        buf_wr_sel_d   = buf_wr_sel_q;
        buf_wr_addr_d  = buf_wr_addr_q;
        buf_wr_data_d  = buf_wr_data_q;
        wr_ptr_d       = wr_ptr_q;
        res_rd_addr_d  = res_rd_addr_q;
        is_rd_d        = is_rd_q;
        start_toggle_d = start_toggle_q;
        err_flag_d     = err_flag_q;
`ifdef SPI_ECHO_EN
        echo_d         = byte_ok ? rx_byte : echo_q;
`endif

        // The first status byte was captured at the negedge that entered STATUS, so the
        // flag can be dropped from the first posedge in this state onwards.
        if (state_q == STATUS) begin
            err_flag_d = 1'b0;
        end

        if (byte_ok) begin
            case (state_q)
                CMD: begin
                    case (rx_byte)
                        OP_WR_A: begin
                            state_d      = ADDR;
                            buf_wr_sel_d = 1'b0;
                            is_rd_d      = 1'b0;
                        end
                        OP_WR_B: begin
                            state_d      = ADDR;
                            buf_wr_sel_d = 1'b1;
                            is_rd_d      = 1'b0;
                        end
                        OP_RD_RES: begin
                            state_d = ADDR;
                            is_rd_d = 1'b1;
                        end
                        OP_START: begin
                            start_toggle_d = ~start_toggle_q;
                            state_d        = IGNORE;
                        end
                        OP_RD_STATUS: begin
                            state_d = STATUS;
                        end
                        default: begin
                            err_flag_d = 1'b1;
                            state_d    = IGNORE;
                        end
                    endcase
                end
                ADDR: begin
                    if (is_rd_q) begin
                        state_d       = RDATA;
                        res_rd_addr_d = rx_byte[ADDR_W-1:0];
                    end else begin
                        state_d  = WDATA;
                        wr_ptr_d = rx_byte[ADDR_W-1:0];
                    end
                end
                WDATA: begin
                    buf_wr_en_d   = 1'b1;
                    buf_wr_addr_d = wr_ptr_q;
                    buf_wr_data_d = rx_byte;
                    wr_ptr_d      = wr_ptr_q + ADDR_W'(1);
                end
                RDATA: begin
                    res_rd_addr_d = res_rd_addr_q + ADDR_W'(1);
                end
                default: begin
                    // STATUS and IGNORE consume bytes until cs_n rises
                end
            endcase
        end
    end

    // Byte presented to the transmit shifter; sampled at negedge sclk
    always_comb begin
        tx_en   = 1'b0;
        tx_byte = 8'h00;
        case (state_q)
            RDATA: begin
                tx_en   = 1'b1;
                tx_byte = buf_if.res_rd_data;
            end
            STATUS: begin
                tx_en   = 1'b1;
                tx_byte = status_byte(busy_s, err_flag_q);
            end
`ifdef SPI_ECHO_EN
            ADDR, WDATA: begin
                tx_en   = 1'b1;
                tx_byte = echo_q;
            end
`endif
            default: begin
                tx_en   = 1'b0;
                tx_byte = 8'h00;
            end
        endcase
    end

    // Frame-scoped state: cleared whenever cs_n is high
    always_ff @(posedge sclk or negedge rst_n or posedge cs_n) begin
        if (!rst_n) begin
            state_q     <= CMD;
            buf_wr_en_q <= 1'b0;
            armed_q     <= 1'b0;
        end else if (cs_n) begin
            state_q     <= CMD;
            buf_wr_en_q <= 1'b0;
            armed_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            buf_wr_en_q <= buf_wr_en_d;
        end
    end

    // State that survives cs_n: addresses, start toggle, error flag, busy synchroniser
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            buf_wr_sel_q   <= 1'b0;
            buf_wr_addr_q  <= '0;
            buf_wr_data_q  <= 8'h00;
            wr_ptr_q       <= '0;
            res_rd_addr_q  <= '0;
            is_rd_q        <= 1'b0;
            start_toggle_q <= 1'b0;
            err_flag_q     <= 1'b0;
            busy_sync_q    <= '0;
`ifdef SPI_ECHO_EN
            echo_q         <= 8'h00;
`endif
        end else begin
            buf_wr_sel_q   <= buf_wr_sel_d;
            buf_wr_addr_q  <= buf_wr_addr_d;
            buf_wr_data_q  <= buf_wr_data_d;
            wr_ptr_q       <= wr_ptr_d;
            res_rd_addr_q  <= res_rd_addr_d;
            is_rd_q        <= is_rd_d;
            start_toggle_q <= start_toggle_d;
            err_flag_q     <= err_flag_d;
            busy_sync_q    <= busy_sync_d;
`ifdef SPI_ECHO_EN
            echo_q         <= echo_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Self-checking bench for spi_frame_sequencer: a host-side driver pushes expected MISO
// bytes and buffer writes into queues; independent monitors pop and compare.
module tb_spi_frame_sequencer;

`ifdef SPI_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic sclk = 1'b0;
    logic rst_n;
    logic cs_n;
    logic mosi;
    logic miso;
    logic start_toggle;
    logic busy_async;

    logic [7:0] res_mem [64];

    spi_frame_sequencer_if #(.ADDR_W(6)) bif ();

    assign bif.res_rd_data = res_mem[bif.res_rd_addr];

    spi_frame_sequencer #(
        .ADDR_W      (6),
        .SYNC_STAGES (2)
    ) dut (
        .sclk         (sclk),
        .rst_n        (rst_n),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .buf_if       (bif),
        .start_toggle (start_toggle),
        .busy_async   (busy_async)
    );

    always #5 sclk = ~sclk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  exp_miso_q [$];
    logic [14:0] exp_wr_q [$];   // {sel, addr[5:0], data[7:0]}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Host-side miso sniffer: assembles a byte every 8 posedges of a live frame
    initial begin
        int         cnt;
        logic [7:0] sb;
        logic [7:0] e;
        cnt = 0;
        sb  = 8'h00;
        forever begin
            @(posedge sclk);
            if (cs_n !== 1'b0 || rst_n !== 1'b1) begin
                cnt = 0;
            end else begin
                sb  = {sb[6:0], miso};
                cnt = cnt + 1;
                if (cnt == 8) begin
                    cnt = 0;
                    if (exp_miso_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL miso_unexpected_byte: got 0x%0h, expected none", sb);
                    end else begin
                        e = exp_miso_q.pop_front();
                        check("miso_byte", {24'h0, sb}, {24'h0, e});
                    end
                end
            end
        end
    end

    // Buffer write monitor: buf_wr_en is stable at negedge
    initial begin
        logic [14:0] w;
        forever begin
            @(negedge sclk);
            if (bif.buf_wr_en === 1'b1) begin
                if (exp_wr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL buf_wr_unexpected: got sel=%0d addr=0x%0h data=0x%0h, expected none",
                             bif.buf_wr_sel, bif.buf_wr_addr, bif.buf_wr_data);
                end else begin
                    w = exp_wr_q.pop_front();
                    check("buf_wr", {17'h0, bif.buf_wr_sel, bif.buf_wr_addr, bif.buf_wr_data},
                          {17'h0, w});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // All driver tasks start and end at negedge+1
    task automatic send_byte(input logic [7:0] b, input logic [7:0] exp_miso);
        exp_miso_q.push_back(exp_miso);
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            @(negedge sclk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            @(negedge sclk);
            #1;
        end
    endtask

    task automatic begin_frame();
        cs_n = 1'b0;
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (2) begin
            @(negedge sclk);
            #1;
        end
    endtask

    function automatic logic [7:0] echo_of(input logic [7:0] b);
        return ECHO ? b : 8'h00;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) res_mem[i] = 8'(i * 3 + 1);
        res_mem[0]  = 8'h12; res_mem[1]  = 8'h34; res_mem[2]  = 8'h56; res_mem[3]  = 8'h78;
        res_mem[12] = 8'hDE; res_mem[13] = 8'hAD; res_mem[14] = 8'hBE; res_mem[15] = 8'hEF;

        rst_n      = 1'b0;
        cs_n       = 1'b1;
        mosi       = 1'b0;
        busy_async = 1'b0;
        repeat (3) @(negedge sclk);
        #1;
        check("rst_miso", {31'h0, miso}, 32'h0);
        check("rst_wr_en", {31'h0, bif.buf_wr_en}, 32'h0);
        check("rst_wr_sel", {31'h0, bif.buf_wr_sel}, 32'h0);
        check("rst_wr_addr", {26'h0, bif.buf_wr_addr}, 32'h0);
        check("rst_wr_data", {24'h0, bif.buf_wr_data}, 32'h0);
        check("rst_rd_addr", {26'h0, bif.res_rd_addr}, 32'h0);
        check("rst_start_toggle", {31'h0, start_toggle}, 32'h0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge sclk);
            #1;
        end

        // WR_A with address wrap 0x3F -> 0x00
        exp_wr_q.push_back({1'b0, 6'h3E, 8'hAA});
        exp_wr_q.push_back({1'b0, 6'h3F, 8'hBB});
        exp_wr_q.push_back({1'b0, 6'h00, 8'hCC});
        begin_frame();
        send_byte(8'h01, 8'h00);
        send_byte(8'h3E, echo_of(8'h01));
        send_byte(8'hAA, echo_of(8'h3E));
        send_byte(8'hBB, echo_of(8'hAA));
        send_byte(8'hCC, echo_of(8'hBB));
        end_frame();

        // WR_B: selects buffer B
        exp_wr_q.push_back({1'b1, 6'h10, 8'h55});
        begin_frame();
        send_byte(8'h02, 8'h00);
        send_byte(8'h10, echo_of(8'h02));
        send_byte(8'h55, echo_of(8'h10));
        end_frame();

        // RD_RES word3 then word0, no dummy byte before the first result byte
        begin_frame();
        send_byte(8'h04, 8'h00);
        send_byte(8'h0C, echo_of(8'h04));
        send_byte(8'h00, 8'hDE);
        send_byte(8'h00, 8'hAD);
        send_byte(8'h00, 8'hBE);
        send_byte(8'h00, 8'hEF);
        end_frame();
        begin_frame();
        send_byte(8'h04, 8'h00);
        send_byte(8'h00, echo_of(8'h04));
        send_byte(8'h00, 8'h12);
        send_byte(8'h00, 8'h34);
        send_byte(8'h00, 8'h56);
        send_byte(8'h00, 8'h78);
        end_frame();

        // START twice in separate frames
        begin_frame();
        send_byte(8'h03, 8'h00);
        end_frame();
        check("start_toggle_1", {31'h0, start_toggle}, 32'h1);
        begin_frame();
        send_byte(8'h03, 8'h00);
        end_frame();
        check("start_toggle_2", {31'h0, start_toggle}, 32'h0);

        // Bad opcode sets the error flag; first status read reports and clears it
        begin_frame();
        send_byte(8'h7F, 8'h00);
        end_frame();
        begin_frame();
        send_byte(8'h05, 8'h00);
        send_byte(8'h00, 8'h40);
        end_frame();
        begin_frame();
        send_byte(8'h05, 8'h00);
        send_byte(8'h00, 8'h00);
        send_byte(8'h00, 8'h00);
        end_frame();
        busy_async = 1'b1;
        repeat (4) begin
            @(negedge sclk);
            #1;
        end
        begin_frame();
        send_byte(8'h05, 8'h00);
        send_byte(8'h00, 8'h80);
        end_frame();
        busy_async = 1'b0;

        // Abort 5 bits into a WDATA byte: no write, next frame decodes as a command
        begin_frame();
        send_byte(8'h01, 8'h00);
        send_byte(8'h05, echo_of(8'h01));
        send_bits(8'hFF, 5);
        end_frame();
        begin_frame();
        send_byte(8'h03, 8'h00);
        end_frame();
        check("start_after_abort", {31'h0, start_toggle}, 32'h1);

        // Reset in the middle of an RDATA byte (0x56 = 0101_0110)
        begin_frame();
        send_byte(8'h04, 8'h00);
        send_byte(8'h00, echo_of(8'h04));
        send_byte(8'h00, 8'h12);
        send_byte(8'h00, 8'h34);
        send_bits(8'h00, 1);
        check("miso_pre_rst", {31'h0, miso}, 32'h1);
        check("rd_addr_pre_rst", {26'h0, bif.res_rd_addr}, 32'h2);
        rst_n = 1'b0;
        #1;
        check("miso_in_rst", {31'h0, miso}, 32'h0);
        check("rd_addr_in_rst", {26'h0, bif.res_rd_addr}, 32'h0);
        check("start_toggle_in_rst", {31'h0, start_toggle}, 32'h0);
        repeat (2) @(negedge sclk);
        #1;
        rst_n = 1'b1;
        // cs_n has not cycled since the reset: this START must be ignored
        send_byte(8'h03, 8'h00);
        check("start_ignored_after_rst", {31'h0, start_toggle}, 32'h0);
        end_frame();
        begin_frame();
        send_byte(8'h03, 8'h00);
        end_frame();
        check("start_after_cs_cycle", {31'h0, start_toggle}, 32'h1);

        repeat (4) @(negedge sclk);
        check("miso_queue_drained", exp_miso_q.size(), 32'h0);
        check("wr_queue_drained", exp_wr_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_frame_sequencer.md
Name: spi_frame_sequencer

Overview:
- SCLK-domain command sequencer that sits between the SPI pins and the accelerator's byte-addressed operand/result buffers.
- Deserialises SPI mode-0 frames, decodes the opcode, auto-increments a byte address, and drives buffer write/read ports.
- Issues a CDC-safe start toggle and serialises status and result bytes onto MISO.
- Replaces sys_clk-side byte decoding, so no per-byte CDC handshake is needed.

Parameters:
- ADDR_W, 6, byte-address width per buffer (64 bytes = 16 x 32-bit words).
- SYNC_STAGES, 2, synchroniser depth for busy_async into SCLK domain.

Ports:
- sclk  in  1  SPI clock; the only clock of this block.
- rst_n  in  1  Reset: asynchronous, active-low.
- cs_n  in  1  Chip select, active-low; high asynchronously aborts the frame.
- mosi  in  1  Serial data in, sampled on posedge sclk, MSB first.
- miso  out  1  Serial data out, updated on negedge sclk, MSB first.
- buf_wr_en  out  1  One-SCLK write strobe.
- buf_wr_sel  out  1  0 = matrix A buffer, 1 = matrix B buffer.
- buf_wr_addr  out  ADDR_W  Write byte address.
- buf_wr_data  out  8  Write byte.
- res_rd_addr  out  ADDR_W  Result byte address; byte 4k is MSB of word k.
- res_rd_data  in  8  Combinational read data for res_rd_addr.
- start_toggle  out  1  Flips once per accepted START; sys_clk side edge-detects it.
- busy_async  in  1  Accelerator busy, sys_clk domain.

Behaviour:
- Reset values: miso=0, buf_wr_en=0, buf_wr_sel=0, buf_wr_addr=0, buf_wr_data=0, res_rd_addr=0, start_toggle=0, err_flag=0, FSM=CMD, bit_cnt=0.
- cs_n high clears the following asynchronously: bit_cnt=0, FSM=CMD, buf_wr_en=0, miso=0. A partial byte is discarded.
- cs_n high does not clear err_flag, start_toggle or the address registers.
- Byte completes on the posedge where bit_cnt==7; rx_byte={shift[6:0],mosi}. bit_cnt wraps to 0.
- Opcodes: 0x01 WR_A, 0x02 WR_B, 0x03 START, 0x04 RD_RES, 0x05 RD_STATUS.
- CMD state:
  - 0x01/0x02 -> ADDR.
  - 0x04 -> ADDR.
  - 0x03 -> flip start_toggle at that edge; -> IGNORE.
  - 0x05 -> STATUS.
  - Any other byte -> set err_flag; -> IGNORE.
- ADDR state:
  - Address = rx_byte[ADDR_W-1:0]; upper bits ignored.
  - Next state WDATA for writes, RDATA for reads.
  - For reads, res_rd_addr=addr at this edge.
- WDATA state, each completed byte:
  - buf_wr_en=1 for exactly that SCLK cycle; buf_wr_data=rx_byte; buf_wr_addr=current address.
  - Address then +1 mod 2^ADDR_W; 63 wraps to 0.
- RDATA/STATUS transmit timing:
  - On the negedge following each byte-complete edge, tx_shift loads the new tx byte and miso=byte[7].
  - Other negedges shift tx_shift left and drive miso=tx_shift[6].
  - Tx byte is res_rd_data in RDATA and status in STATUS.
- RDATA: res_rd_addr +1 (wrapping) at each byte-complete edge. First result byte follows the address byte with zero dummy bytes.
- STATUS: byte = {busy_s, err_flag, 6'b0}. The first byte loaded clears err_flag at that negedge load. Later bytes repeat status.
- IGNORE: consumes bytes until cs_n high.
- miso is 0 in CMD, ADDR, WDATA and IGNORE (see Optional Feature).
- busy_s: busy_async through SYNC_STAGES flops on sclk, reset 0. Valid only after SYNC_STAGES SCLK edges; hosts send one dummy byte first.
- START is accepted while busy_s=1; queuing/rejecting is the sys_clk side's job.
- rst_n mid-frame: all state returns to reset values; the frame resumes only after cs_n cycles.

Optional Feature:
- Macro SPI_ECHO_EN.
- Defined: in WDATA and ADDR, miso shifts out the previously received byte (loopback check), loaded at the same negedge slot as reads.
- Undefined: miso is 0 in those states.

Decomposition:
- Package spi_seq_pkg holds:
  - Opcode constants OP_WR_A, OP_WR_B, OP_START, OP_RD_RES, OP_RD_STATUS.
  - State enum {CMD, ADDR, WDATA, RDATA, STATUS, IGNORE}.
  - ADDR_W default and the status bit positions.
- One sub-module, spi_byte_shifter, holds bit_cnt, rx shift and tx shift. It outputs byte_done and rx_byte, and takes tx_byte.

Test Plan:
- WR_A frame 0x01,0x3E,0xAA,0xBB,0xCC -> three buf_wr_en pulses, sel=0: (0x3E,0xAA), (0x3F,0xBB), (0x00,0xCC) wrap.
- Results word0=0x12345678, word3=0xDEADBEEF; frame 0x04,0x0C,4 dummy bytes -> MISO bytes DE,AD,BE,EF; then readdress 0x00 -> 12,34,56,78.
- Frame 0x03 twice in separate frames -> start_toggle 0->1->0; buffers untouched.
- Bad opcode 0x7F then frame 0x05,0x00 -> status 0x40; second status frame -> 0x00. With busy_async=1 held -> 0x80.
- cs_n raised after 5 bits of a WDATA byte -> no buf_wr_en; the next frame's first byte decodes as a command.
- rst_n asserted mid-RDATA -> miso=0, res_rd_addr=0, start_toggle=0 immediately; SPI_ECHO_EN build: WR_B frame 0x02,0x10,0x55 -> 0x10 appears on miso during the 0x55 byte.
